cpu_fsm: RTL and testbench

- Control unit for the 16-bit CR16-style teaching CPU.
- Sequences each instruction through FETCH, EXECUTE and (for LOAD) MEM states.
- Decodes the instruction word into ALU function, register addresses, immediate and the datapath enables: register-file write, RAM write and PC advance.
- Sits between instruction memory and the datapath (register file, ALU, RAM, PC).

---
 rtl/cpu_fsm.sv | 179 +++++++++++++++++
 tb/tb_cpu_fsm.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cpu_fsm.sv
// Control unit for the 16-bit CR16-style teaching CPU: sequences FETCH/EXECUTE/MEM
// and decodes each instruction word into ALU function, operand select and datapath enables.
module cpu_fsm (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] Instr,
   input  logic [4:0]  ALUFlags,
   output logic        Imm_s,
   output logic        RegEn,
   output logic        RAMEn,
   output logic        PCEn,
   output logic        Signed,
   output logic [3:0]  ALUOpCode,
   output logic [3:0]  RdestRegLoc,
   output logic [3:0]  RsrcRegLoc,
   output logic [7:0]  Imm
);

   localparam int unsigned FIELD_W = 4;
   localparam int unsigned FLAG_W  = 5;
   localparam int unsigned IMM_W   = 8;

   localparam logic [FIELD_W-1:0] OP_REG   = 4'b0000;
   localparam logic [FIELD_W-1:0] OP_MEM   = 4'b0100;
   localparam logic [FIELD_W-1:0] OP_SHIFT = 4'b1000;
   localparam logic [FIELD_W-1:0] OP_LUI   = 4'b1111;

   localparam logic [FIELD_W-1:0] F_ADD  = 4'b0101;
   localparam logic [FIELD_W-1:0] F_ADDU = 4'b0110;
   localparam logic [FIELD_W-1:0] F_ADDC = 4'b0111;
   localparam logic [FIELD_W-1:0] F_SUB  = 4'b1001;
   localparam logic [FIELD_W-1:0] F_CMP  = 4'b1011;
   localparam logic [FIELD_W-1:0] F_LSH  = 4'b0100;
   localparam logic [FIELD_W-1:0] F_STOR = 4'b1100;
   localparam logic [FIELD_W-1:0] F_MEMP = 4'b1110;

   localparam logic [FIELD_W-1:0] EXT_LOAD = 4'b0000;
   localparam logic [FIELD_W-1:0] EXT_STOR = 4'b0100;
   localparam logic [FIELD_W-1:0] EXT_LSH  = 4'b0100;

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_EXECUTE = 2'd1,
      S_MEM     = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [FLAG_W-1:0]  psr_q;

   logic [FIELD_W-1:0] op, ext;
   logic               dec_imm_s, dec_regen, dec_ramen, dec_signed, dec_load, dec_flags;
   logic [FIELD_W-1:0] dec_alu;
   logic               psr_unused;

   // ALU functions shared by register and immediate forms
   function automatic logic alu_valid(input logic [FIELD_W-1:0] f);
      case (f)
         4'b0001, 4'b0010, 4'b0011, F_ADD, F_ADDU, F_ADDC,
         F_SUB, F_CMP, 4'b1101: alu_valid = 1'b1;
         default:              alu_valid = 1'b0;
      endcase
   endfunction

   function automatic logic alu_signed(input logic [FIELD_W-1:0] f);
      alu_signed = (f == F_ADD) || (f == F_ADDC) || (f == F_SUB) || (f == F_CMP);
   endfunction

   function automatic logic alu_flags(input logic [FIELD_W-1:0] f);
      alu_flags = alu_signed(f) || (f == F_ADDU);
   endfunction

   assign op          = Instr[15:12];
   assign ext         = Instr[7:4];
   assign RdestRegLoc = Instr[11:8];
   assign RsrcRegLoc  = Instr[3:0];
   assign Imm         = ((op == OP_SHIFT) && (ext[3:1] == 3'b000))
                        ? IMM_W'({3'b000, Instr[4:0]}) : Instr[7:0];

   // EXECUTE-cycle decode; undefined encodings and branches fall through as NOP
   always_comb begin
      dec_imm_s  = 1'b0;
      dec_regen  = 1'b0;
      dec_ramen  = 1'b0;
      dec_signed = 1'b0;
      dec_load   = 1'b0;
      dec_flags  = 1'b0;
      dec_alu    = '0;
      case (op)
         OP_REG: begin
            if (alu_valid(ext)) begin
               dec_alu    = ext;
               dec_regen  = (ext != F_CMP);
               dec_signed = alu_signed(ext);
               dec_flags  = alu_flags(ext);
            end
         end
         OP_MEM: begin
            if (ext == EXT_STOR) begin
               dec_ramen = 1'b1;
               dec_alu   = F_STOR;
            end else if (ext == EXT_LOAD) begin
               dec_load = 1'b1;
               dec_alu  = F_MEMP;
            end
         end
         OP_SHIFT: begin
            if (ext == EXT_LSH) begin
               dec_alu   = F_LSH;
               dec_regen = 1'b1;
            end else if (ext[3:1] == 3'b000) begin
               dec_alu   = F_LSH;
               dec_imm_s = 1'b1;
               dec_regen = 1'b1;
            end
         end
         default: begin
            if (alu_valid(op) || (op == OP_LUI)) begin
               dec_alu    = op;
               dec_imm_s  = 1'b1;
               dec_regen  = (op != F_CMP);
               dec_signed = alu_signed(op);
               dec_flags  = alu_flags(op);
            end
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Next state and datapath enables; reset blanks everything in the same cycle
   always_comb begin
      state_d   = state_q;
      Imm_s     = 1'b0;
      RegEn     = 1'b0;
      RAMEn     = 1'b0;
      PCEn      = 1'b0;
      Signed    = 1'b0;
      ALUOpCode = '0;
      case (state_q)
         S_FETCH: state_d = S_EXECUTE;
         S_EXECUTE: begin
            Imm_s     = dec_imm_s;
            RegEn     = dec_regen;
            RAMEn     = dec_ramen;
            Signed    = dec_signed;
            ALUOpCode = dec_alu;
            PCEn      = ~dec_load;
            state_d   = dec_load ? S_MEM : S_FETCH;
         end
         S_MEM: begin
            RegEn     = 1'b1;
            ALUOpCode = F_MEMP;
            PCEn      = 1'b1;
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      if (Reset) begin
         Imm_s     = 1'b0;
         RegEn     = 1'b0;
         RAMEn     = 1'b0;
         PCEn      = 1'b0;
         Signed    = 1'b0;
         ALUOpCode = '0;
      end
   end

   // PSR is held for future conditional branches; nothing consumes it yet
   always_ff @(posedge Clk) begin
      if (Reset)                                 psr_q <= '0;
      else if ((state_q == S_EXECUTE) && dec_flags) psr_q <= ALUFlags;
   end

   assign psr_unused = ^psr_q;

endmodule

// File: tb/tb_cpu_fsm.sv
// Directed testbench for cpu_fsm: hand-computed control vectors per instruction class.
module tb_cpu_fsm;

   logic        Clk;
   logic        Reset;
   logic [15:0] Instr;
   logic [4:0]  ALUFlags;
   logic        Imm_s, RegEn, RAMEn, PCEn, Signed;
   logic [3:0]  ALUOpCode, RdestRegLoc, RsrcRegLoc;
   logic [7:0]  Imm;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_fsm dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Instr       (Instr),
      .ALUFlags    (ALUFlags),
      .Imm_s       (Imm_s),
      .RegEn       (RegEn),
      .RAMEn       (RAMEn),
      .PCEn        (PCEn),
      .Signed      (Signed),
      .ALUOpCode   (ALUOpCode),
      .RdestRegLoc (RdestRegLoc),
      .RsrcRegLoc  (RsrcRegLoc),
      .Imm         (Imm)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // {Imm_s, RegEn, RAMEn, PCEn, Signed, ALUOpCode}
   function automatic logic [8:0] ctrl();
      return {Imm_s, RegEn, RAMEn, PCEn, Signed, ALUOpCode};
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Present instr in FETCH, check FETCH is quiet, then check EXECUTE and return to FETCH
   task automatic run_instr(input string tag, input logic [15:0] ins, input logic [4:0] flags,
                            input logic [8:0] exp_exec, input logic [7:0] exp_imm);
      Instr    = ins;
      ALUFlags = flags;
      #1;
      chk({tag, "_fetch"}, 16'(ctrl()), 16'h0);
      tick();
      chk({tag, "_exec"}, 16'(ctrl()), 16'(exp_exec));
      chk({tag, "_imm"}, 16'(Imm), 16'(exp_imm));
      tick();
   endtask

   initial begin
      Reset    = 1'b1;
      Instr    = 16'h0153;
      ALUFlags = 5'b00000;
      tick();
      tick();
      chk("reset_ctrl", 16'(ctrl()), 16'h0);
      chk("reset_rdest", 16'(RdestRegLoc), 16'h1);
      chk("reset_rsrc", 16'(RsrcRegLoc), 16'h3);
      chk("reset_psr", 16'(dut.psr_q), 16'h0);

      Reset = 1'b0;
      #1;
      chk("add_cycle1", 16'(ctrl()), 16'h0);
      tick();
      chk("add_exec", 16'(ctrl()), 16'(9'b0_1_0_1_1_0101));
      tick();

      run_instr("addi",  16'h5A85, 5'b00000, 9'b1_1_0_1_1_0101, 8'h85);
      chk("psr_addi", 16'(dut.psr_q), 16'h00);
      run_instr("cmp",   16'h02B4, 5'b00010, 9'b0_0_0_1_1_1011, 8'hB4);
      chk("psr_cmp", 16'(dut.psr_q), 16'h02);
      run_instr("cmpi",  16'hB207, 5'b00101, 9'b1_0_0_1_1_1011, 8'h07);
      chk("psr_cmpi", 16'(dut.psr_q), 16'h05);
      run_instr("andi",  16'h3A85, 5'b11111, 9'b1_1_0_1_0_0011, 8'h85);
      chk("psr_andi_hold", 16'(dut.psr_q), 16'h05);
      run_instr("addu",  16'h0163, 5'b01000, 9'b0_1_0_1_0_0110, 8'h63);
      chk("psr_addu", 16'(dut.psr_q), 16'h08);
      run_instr("mov",   16'h01D2, 5'b10000, 9'b0_1_0_1_0_1101, 8'hD2);
      chk("psr_mov_hold", 16'(dut.psr_q), 16'h08);
      run_instr("stor",  16'h4344, 5'b00000, 9'b0_0_1_1_0_1100, 8'h44);
      run_instr("lshi",  16'h8314, 5'b00000, 9'b1_1_0_1_0_0100, 8'h14);
      run_instr("lsh",   16'h8344, 5'b00000, 9'b0_1_0_1_0_0100, 8'h44);
      run_instr("bcond", 16'hC105, 5'b00000, 9'b0_0_0_1_0_0000, 8'h05);
      run_instr("lui",   16'hF1AB, 5'b00000, 9'b1_1_0_1_0_1111, 8'hAB);
      run_instr("undef_reg", 16'h0004, 5'b00000, 9'b0_0_0_1_0_0000, 8'h04);
      run_instr("undef_op",  16'hE123, 5'b00000, 9'b0_0_0_1_0_0000, 8'h23);
      run_instr("jump",      16'h41C2, 5'b00000, 9'b0_0_0_1_0_0000, 8'hC2);

      // LOAD takes three cycles
      Instr = 16'h4304;
      #1;
      chk("load_fetch", 16'(ctrl()), 16'h0);
      tick();
      chk("load_exec", 16'(ctrl()), 16'(9'b0_0_0_0_0_1110));
      chk("load_rsrc", 16'(RsrcRegLoc), 16'h4);
      tick();
      chk("load_mem", 16'(ctrl()), 16'(9'b0_1_0_1_0_1110));
      tick();
      chk("load_back_fetch", 16'(ctrl()), 16'h0);

      // Reset during MEM abandons the LOAD
      tick();
      chk("rload_exec", 16'(ctrl()), 16'(9'b0_0_0_0_0_1110));
      tick();
      Reset = 1'b1;
      #1;
      chk("rload_mem_in_reset", 16'(ctrl()), 16'h0);
      tick();
      Reset = 1'b0;
      #1;
      chk("rload_fetch", 16'(ctrl()), 16'h0);
      chk("rload_psr", 16'(dut.psr_q), 16'h0);
      tick();
      chk("rload_reexec", 16'(ctrl()), 16'(9'b0_0_0_0_0_1110));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
